fetch_stage: RTL

//  MIPS instruction-fetch stage with its IF/ID pipeline register. It owns the PC, drives the

---
 rtl/mips_pkg.sv | 24 ++
 rtl/pc_next_sel.sv | 44 ++++
 rtl/fetch_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants and the fetch next-PC select encoding.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [2:0] {
      PC_SEL_HOLD   = 3'd0,
      PC_SEL_JUMP   = 3'd1,
      PC_SEL_BRANCH = 3'd2,
      PC_SEL_SEQ    = 3'd3,
      PC_SEL_WAIT   = 3'd4
   } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC arithmetic and priority select for the fetch stage.
module pc_next_sel
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] id_pc_plus4,
   input  logic        id_valid,
   input  logic        stall,
   input  logic        jump,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   input  logic [25:0] jump_index,
   input  logic        imem_ready,
   output logic [31:0] pc_plus4,
   output logic [31:0] br_tgt,
   output logic [31:0] j_tgt,
   output pc_sel_e     sel
);

   logic jump_q_ok;
   logic branch_q_ok;

   assign pc_plus4 = pc + 32'd4;
   assign br_tgt   = id_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
   assign j_tgt    = {id_pc_plus4[31:28], jump_index, 2'b00};

   // A bubble in ID cannot be a branch or jump, so its redirect lines are ignored.
   assign jump_q_ok   = jump & id_valid;
   assign branch_q_ok = branch_taken & id_valid;

   always_comb begin
      sel = PC_SEL_WAIT;
      if (stall) begin
         sel = PC_SEL_HOLD;
      end else if (jump_q_ok) begin
         sel = PC_SEL_JUMP;
      end else if (branch_q_ok) begin
         sel = PC_SEL_BRANCH;
      end else if (imem_ready) begin
         sel = PC_SEL_SEQ;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, imem interface and IF/ID pipeline register.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_WORD  = NOP_INSTR
)(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] id_instr,
   output logic [5:0]  id_op_code,
   output logic [31:0] id_pc_plus4,
   output logic        id_valid
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
   logic        id_valid_q, id_valid_d;

   logic [31:0] pc_plus4;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   pc_sel_e     sel;

   pc_next_sel u_pc_next_sel (
      .pc            (pc_q),
      .id_pc_plus4   (id_pc_plus4_q),
      .id_valid      (id_valid_q),
      .stall         (stall),
      .jump          (jump),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump_index    (jump_index),
      .imem_ready    (imem_ready),
      .pc_plus4      (pc_plus4),
      .br_tgt        (br_tgt),
      .j_tgt         (j_tgt),
      .sel           (sel)
   );

   // A bubble clears the instruction and valid bit but keeps id_pc_plus4.
   always_comb begin
      pc_d          = pc_q;
      id_instr_d    = id_instr_q;
      id_pc_plus4_d = id_pc_plus4_q;
      id_valid_d    = id_valid_q;
      case (sel)
         PC_SEL_HOLD: begin
         end
         PC_SEL_JUMP: begin
            pc_d       = j_tgt;
            id_instr_d = NOP_WORD;
            id_valid_d = 1'b0;
         end
         PC_SEL_BRANCH: begin
            pc_d       = br_tgt;
            id_instr_d = NOP_WORD;
            id_valid_d = 1'b0;
         end
         PC_SEL_SEQ: begin
            pc_d          = pc_plus4;
            id_instr_d    = imem_rdata;
            id_pc_plus4_d = pc_plus4;
            id_valid_d    = 1'b1;
         end
         PC_SEL_WAIT: begin
            id_instr_d = NOP_WORD;
            id_valid_d = 1'b0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         id_instr_q    <= NOP_WORD;
         id_pc_plus4_q <= 32'h0000_0000;
         id_valid_q    <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         id_instr_q    <= id_instr_d;
         id_pc_plus4_q <= id_pc_plus4_d;
         id_valid_q    <= id_valid_d;
      end
   end

   assign imem_addr   = pc_q;
   assign imem_req    = ~reset;
   assign id_instr    = id_instr_q;
   assign id_op_code  = id_instr_q[31:26];
   assign id_pc_plus4 = id_pc_plus4_q;
   assign id_valid    = id_valid_q;

endmodule
